// File: rtl/player_laser_ctrl_if.sv
// Signal bundle between the player laser sequencer and the ship / collision / draw logic.
// Signal names keep the original _i/_o port names so existing hookups map one-to-one.
interface player_laser_ctrl_if;
    logic       shoot_i;
    logic       alive_i;
    logic       freeze_i;
    logic [9:0] gun_pos_i;
    logic       hit_enemy_i;
    logic       laser_active_o;
    logic [9:0] laser_x_o;
    logic [9:0] laser_y_o;
    logic       shot_laser_o;
    logic       laser_miss_o;
    logic [1:0] state_o;

    modport slave (
        input  shoot_i, alive_i, freeze_i, gun_pos_i, hit_enemy_i,
        output laser_active_o, laser_x_o, laser_y_o, shot_laser_o, laser_miss_o, state_o
    );

    modport master (
        output shoot_i, alive_i, freeze_i, gun_pos_i, hit_enemy_i,
        input  laser_active_o, laser_x_o, laser_y_o, shot_laser_o, laser_miss_o, state_o
    );
endinterface

// File: rtl/player_laser_ctrl.sv
// Single player laser: spawns on a button edge, climbs on a divided tick,
// retires on hit or top border, then holds a re-fire cooldown.
module player_laser_ctrl #(
    parameter logic [19:0] tick_div_p   = 20'd833333,
    parameter logic [9:0]  step_p       = 10'd8,
    parameter logic [9:0]  spawn_y_p    = 10'd440,
    parameter logic [9:0]  top_border_p = 10'd8,
    parameter logic [19:0] cooldown_p   = 20'd2500000
) (
    input  logic               clk_i,
    input  logic               reset_i,
    player_laser_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        FLIGHT   = 2'b01,
        COOLDOWN = 2'b10
    } state_t;

    state_t      state, state_nx;
    logic [19:0] tick_cnt, tick_nx;
    logic [19:0] cd_cnt, cd_nx;
    logic        shoot_prev;
    logic        active, active_nx;
    logic        shot, shot_nx;
    logic        miss, miss_nx;
    logic [9:0]  x, x_nx;
    logic [9:0]  y, y_nx;
    logic        fire;
    logic        step_due;
    logic        at_top;

    assign fire     = bus.shoot_i & ~shoot_prev & ~bus.freeze_i & bus.alive_i;
    assign step_due = (tick_cnt == tick_div_p - 20'd1);
    // widened compare so a large border+step cannot wrap
    assign at_top   = {1'b0, y} < ({1'b0, top_border_p} + {1'b0, step_p});

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            cd_cnt     <= '0;
            shoot_prev <= 1'b1;
            active     <= 1'b0;
            shot       <= 1'b0;
            miss       <= 1'b0;
            x          <= '0;
            y          <= '0;
        end else begin
            state      <= state_nx;
            tick_cnt   <= tick_nx;
            cd_cnt     <= cd_nx;
            shoot_prev <= bus.shoot_i;
            active     <= active_nx;
            shot       <= shot_nx;
            miss       <= miss_nx;
            x          <= x_nx;
            y          <= y_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        tick_nx   = tick_cnt;
        cd_nx     = cd_cnt;
        active_nx = active;
        shot_nx   = 1'b0;
        miss_nx   = 1'b0;
        x_nx      = x;
        y_nx      = y;
        if (!bus.alive_i) begin
            state_nx  = IDLE;
            active_nx = 1'b0;
            tick_nx   = '0;
            cd_nx     = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fire) begin
                        state_nx  = FLIGHT;
                        x_nx      = bus.gun_pos_i;
                        y_nx      = spawn_y_p;
                        active_nx = 1'b1;
                        shot_nx   = 1'b1;
                        tick_nx   = '0;
                    end
                end
                FLIGHT: begin
                    if (!bus.freeze_i) begin
                        if (bus.hit_enemy_i) begin
                            active_nx = 1'b0;
                            cd_nx     = '0;
                            state_nx  = COOLDOWN;
                        end else if (step_due) begin
                            tick_nx = '0;
                            if (at_top) begin
                                active_nx = 1'b0;
                                miss_nx   = 1'b1;
                                cd_nx     = '0;
                                state_nx  = COOLDOWN;
                            end else begin
                                y_nx = y - step_p;
                            end
                        end else begin
                            tick_nx = tick_cnt + 20'd1;
                        end
                    end
                end
                COOLDOWN: begin
                    if (!bus.freeze_i) begin
                        if (cd_cnt == cooldown_p - 20'd1) begin
                            cd_nx    = '0;
                            state_nx = IDLE;
                        end else begin
                            cd_nx = cd_cnt + 20'd1;
                        end
                    end
                end
                default: begin
                    state_nx  = IDLE;
                    active_nx = 1'b0;
                    tick_nx   = '0;
                    cd_nx     = '0;
                end
            endcase
        end
    end

    assign bus.laser_active_o = active;
    assign bus.laser_x_o      = x;
    assign bus.laser_y_o      = y;
    assign bus.shot_laser_o   = shot;
    assign bus.laser_miss_o   = miss;
    assign bus.state_o        = state;

endmodule

// File: doc/player_laser_ctrl.md
Name: player_laser_ctrl

Overview:
- Sequences the single player laser (one shot on screen at a time).
- Turns center-button presses into one spawn at the player's gun position, then steps the laser upward on a divided tick.
- Retires the laser on an enemy hit or at the top border, then enforces a re-fire cooldown.
- Sits between the player ship (gun position, alive status, freeze/pause) and the collision/draw logic; drives the shot-spawn pulse.

Parameters:
- tick_div_p, 20'd833333: clock cycles per laser step (non-zero).
- step_p, 10'd8: pixels moved up per step.
- spawn_y_p, 10'd440: laser y (top edge) at spawn.
- top_border_p, 10'd8: top limit; the laser may not step above it.
- cooldown_p, 20'd2500000: cycles in COOLDOWN after the laser retires (non-zero).

Ports:
- clk_i, input, 1: clock.
- reset_i, input, 1: asynchronous, active-high reset.
- shoot_i, input, 1: center button (level); rising edge requests a shot.
- alive_i, input, 1: player has lives; low kills any laser.
- freeze_i, input, 1: level paused (player hit); holds all motion and timers.
- gun_pos_i, input, 10: player gun x position.
- hit_enemy_i, input, 1: collision logic reports that the laser hit something this cycle.
- laser_active_o, output, 1: laser on screen.
- laser_x_o, output, 10: laser x, latched at spawn.
- laser_y_o, output, 10: laser y.
- shot_laser_o, output, 1: one-cycle pulse on spawn.
- laser_miss_o, output, 1: one-cycle pulse when the laser retires at the top border.
- state_o, output, 2: current state (debug): IDLE=00, FLIGHT=01, COOLDOWN=10.

Behaviour:
- Reset (asynchronous, immediate) sets:
  - state IDLE
  - laser_active_o=0, laser_x_o=0, laser_y_o=0
  - shot_laser_o=0, laser_miss_o=0
  - tick and cooldown counters = 0
  - shoot_prev = 1, so a button held through reset or resume does not fire.
- Edge detect:
  - fire = shoot_i & ~shoot_prev & ~freeze_i & alive_i.
  - shoot_prev <= shoot_i every cycle, including during freeze. The resume press therefore never fires a shot.
- IDLE:
  - On fire, at the next edge go to FLIGHT.
  - That same edge sets laser_x_o <= gun_pos_i, laser_y_o <= spawn_y_p, laser_active_o <= 1, shot_laser_o <= 1 for exactly one cycle, and tick counter <= 0.
- FLIGHT:
  - laser_x_o is constant; the laser does not track the ship.
  - Each unfrozen cycle the tick counter increments. When it equals tick_div_p-1 it clears and a step occurs.
  - Step rule: if laser_y_o < top_border_p + step_p, retire as a miss. Otherwise laser_y_o <= laser_y_o - step_p. Unsigned 10-bit compare; laser_y_o never wraps.
  - Miss: laser_active_o <= 0, laser_miss_o pulses one cycle, cooldown counter <= 0, go to COOLDOWN.
  - hit_enemy_i=1 (sampled regardless of tick): laser_active_o <= 0, go to COOLDOWN, no miss pulse. A hit has priority over a step or miss in the same cycle.
  - fire is ignored and not queued.
- COOLDOWN:
  - The counter increments each unfrozen cycle. At cooldown_p-1 go to IDLE.
  - fire is ignored; hit_enemy_i is ignored.
- freeze_i=1 in any state: counters, laser_y_o and state hold; the laser remains visible; hit_enemy_i is ignored. Motion resumes exactly where it stopped.
- alive_i=0 has priority over everything except reset:
  - From any state, at the next edge go to IDLE with laser_active_o=0, no pulses, counters cleared.
- Invalid state encoding (11) recovers to IDLE at the next edge.

Test Plan:
1. Params tick_div_p=4, step_p=8, spawn_y_p=40, top_border_p=8, cooldown_p=6; alive_i=1, gun_pos_i=300; raise shoot_i -> next edge: shot_laser_o=1 for 1 cycle, laser_x_o=300, laser_y_o=40, state_o=01. Then y=32,24,16,8 at 4,8,12,16 cycles after spawn. At 20 cycles: laser_active_o=0, laser_miss_o pulse, state_o=10. IDLE 6 cycles later.
2. Hold shoot_i high across the whole flight and cooldown, and across reset release -> exactly one shot_laser_o pulse and no refire until shoot_i falls and rises again.
3. Change gun_pos_i to 500 mid-flight -> laser_x_o stays 300. Assert hit_enemy_i on the same cycle as a step tick -> laser retires, y not decremented, laser_miss_o=0, COOLDOWN.
4. freeze_i=1 for 10 cycles at y=32 with tick counter=2 -> y holds 32, a shoot edge is ignored, state unchanged. After release, the next step occurs 2 cycles later (y=24).
5. Drop alive_i in FLIGHT -> next edge: IDLE, laser_active_o=0, no pulses. Assert reset_i asynchronously mid-cooldown -> all outputs 0 immediately, state_o=00.
